// File: rtl/apb_mst.sv
// Single-outstanding APB3/APB4 initiator: valid/ready request in, valid/ready response out,
// with an optional PREADY timeout that aborts a transfer to a hung slave.
module apb_mst #(
  parameter int unsigned TIMEOUT       = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_pwrreset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_resp_timeout,
  output logic        o_psel,
  output logic        o_penable,
  output logic [31:0] o_paddr,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  output logic [3:0]  o_pstrb,
  input  logic        i_pready,
  input  logic [31:0] i_prdata,
  input  logic        i_pslverr
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic             r_rdy_en;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             to_hit;

  assign accept = (state == IDLE) && r_rdy_en && i_req_valid;
  assign to_hit = (TIMEOUT != 0) && (cnt == CNT_LIM);

  // Every output is either a flop or a pure decode of the state register.
  assign o_req_ready  = (state == IDLE) && r_rdy_en;
  assign o_psel       = (state == SETUP) || (state == ACCESS);
  assign o_penable    = (state == ACCESS);
  assign o_resp_valid = (state == RESP);

  always_ff @(posedge i_clk or posedge i_pwrreset) begin
    if (i_pwrreset) begin
      state    <= IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (i_pready || to_hit) state_nxt = RESP;
      RESP:   if (i_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, response capture and the saturating ACCESS-wait counter.
  always_ff @(posedge i_clk or posedge i_pwrreset) begin
    if (i_pwrreset) begin
      o_paddr        <= '0;
      o_pwrite       <= 1'b0;
      o_pwdata       <= '0;
      o_pstrb        <= '0;
      o_resp_rdata   <= '0;
      o_resp_err     <= 1'b0;
      o_resp_timeout <= 1'b0;
      cnt            <= '0;
    end else begin
      if (accept) begin
        o_paddr  <= i_req_addr;
        o_pwrite <= i_req_write;
        o_pwdata <= i_req_write ? i_req_wdata : 32'h0;
        o_pstrb  <= i_req_write ? i_req_wstrb : 4'h0;
      end
      if (state == ACCESS) begin
        if (i_pready) begin
          o_resp_rdata   <= o_pwrite ? 32'h0 : i_prdata;
          o_resp_err     <= i_pslverr;
          o_resp_timeout <= 1'b0;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          if (to_hit) begin
            o_resp_rdata   <= o_pwrite ? 32'h0 : TIMEOUT_RDATA;
            o_resp_err     <= 1'b1;
            o_resp_timeout <= 1'b1;
          end
        end
      end
      if ((state == RESP) && i_resp_ready) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_apb_mst.sv
// Directed bench for apb_mst (TIMEOUT=8): APB timing, wait states, errors, timeout,
// backpressure/back-to-back and async reset, with a response scoreboard queue.
module tb_apb_mst;

  logic        i_clk = 1'b0;
  logic        i_pwrreset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_write;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wstrb;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_resp_timeout;
  logic        o_psel;
  logic        o_penable;
  logic [31:0] o_paddr;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready;
  logic [31:0] i_prdata;
  logic        i_pslverr;

  apb_mst #(.TIMEOUT(8), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
    .i_clk(i_clk), .i_pwrreset(i_pwrreset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_write(i_req_write), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_rdata(o_resp_rdata),
    .o_resp_err(o_resp_err), .o_resp_timeout(o_resp_timeout),
    .o_psel(o_psel), .o_penable(o_penable), .o_paddr(o_paddr), .o_pwrite(o_pwrite),
    .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] rdata, input logic err, input logic to);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.to    = to;
    sb.push_back(e);
  endtask

  // Drive one request and return right after the accepting edge (DUT now in SETUP).
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    for (int i = 0; i < 20 && !o_req_ready; i++) tick();
    chk("req_ready_before_issue", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_write = wr;
    i_req_wdata = wdata;
    i_req_wstrb = wstrb;
    tick();
    i_req_valid = 1'b0;
    i_req_wdata = 32'hDEAD_BEEF;
    i_req_wstrb = 4'hF;
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, o_resp_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, o_resp_err}, {31'd0, e.err});
      chk({tag, "_timeout"}, {31'd0, o_resp_timeout}, {31'd0, e.to});
    end
  endtask

  // Bounded wait for a response, compare it, then handshake it.
  task automatic wait_resp(input string tag);
    for (int i = 0; i < 30 && !o_resp_valid; i++) tick();
    chk({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd1);
    chk({tag, "_psel_idle_in_resp"}, {31'd0, o_psel}, 32'd0);
    check_resp(tag);
    i_resp_ready = 1'b1;
    tick();
    chk({tag, "_resp_dropped"}, {31'd0, o_resp_valid}, 32'd0);
  endtask

  initial begin
    i_pwrreset   = 1'b1;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_req_write  = 1'b0;
    i_req_wdata  = '0;
    i_req_wstrb  = '0;
    i_resp_ready = 1'b1;
    i_pready     = 1'b1;
    i_prdata     = '0;
    i_pslverr    = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_psel", {31'd0, o_psel}, 32'd0);
    chk("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_paddr", o_paddr, 32'd0);
    #2 i_pwrreset = 1'b0;
    #1 chk("rst_rel_ready_low", {31'd0, o_req_ready}, 32'd0);
    tick();
    chk("rst_rel_ready_high", {31'd0, o_req_ready}, 32'd1);

    // Write, zero wait states
    push(32'h0, 1'b0, 1'b0);
    issue(32'h0000_0004, 1'b1, 32'hA5A5_0001, 4'hF);
    chk("wr_setup_psel", {31'd0, o_psel}, 32'd1);
    chk("wr_setup_penable", {31'd0, o_penable}, 32'd0);
    chk("wr_paddr", o_paddr, 32'h0000_0004);
    chk("wr_pwrite", {31'd0, o_pwrite}, 32'd1);
    chk("wr_pwdata", o_pwdata, 32'hA5A5_0001);
    chk("wr_pstrb", {28'd0, o_pstrb}, 32'hF);
    chk("wr_setup_req_ready", {31'd0, o_req_ready}, 32'd0);
    tick();
    chk("wr_access_penable", {31'd0, o_penable}, 32'd1);
    chk("wr_access_psel", {31'd0, o_psel}, 32'd1);
    tick();
    chk("wr_resp_at_n3", {31'd0, o_resp_valid}, 32'd1);
    wait_resp("wr0");

    // Read with 3 wait states
    i_pready = 1'b0;
    i_prdata = 32'h0000_0005;
    push(32'h0000_0005, 1'b0, 1'b0);
    issue(32'h0, 1'b0, 32'h1111_2222, 4'hF);
    chk("rd_pwdata_zero", o_pwdata, 32'd0);
    chk("rd_pstrb_zero", {28'd0, o_pstrb}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_ws_access", {31'd0, o_penable}, 32'd1);
      chk("rd_ws_pstrb", {28'd0, o_pstrb}, 32'd0);
      if (i == 3) i_pready = 1'b1;
    end
    tick();
    chk("rd_ws_resp_valid", {31'd0, o_resp_valid}, 32'd1);
    wait_resp("rd_ws");

    // Slave error
    i_pslverr = 1'b1;
    i_prdata  = 32'h0000_1234;
    push(32'h0000_1234, 1'b1, 1'b0);
    issue(32'h0000_0020, 1'b0, 32'h0, 4'h0);
    wait_resp("slverr");
    i_pslverr = 1'b0;

    // Timeout, read
    i_pready = 1'b0;
    i_prdata = 32'h0BAD_0BAD;
    push(32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(32'h0000_0030, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_rd_still_access", {31'd0, o_penable}, 32'd1);
    end
    tick();
    chk("to_rd_abort_after_8", {31'd0, o_resp_valid}, 32'd1);
    wait_resp("to_rd");

    // Timeout, write
    push(32'h0, 1'b1, 1'b1);
    issue(32'h0000_0034, 1'b1, 32'h5555_AAAA, 4'h3);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_wr_still_access", {31'd0, o_penable}, 32'd1);
    end
    tick();
    chk("to_wr_abort_after_8", {31'd0, o_resp_valid}, 32'd1);
    wait_resp("to_wr");

    // PREADY on the 8th ACCESS cycle wins over the timeout
    i_prdata = 32'h0000_0088;
    push(32'h0000_0088, 1'b0, 1'b0);
    issue(32'h0000_0038, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) i_pready = 1'b1;
    end
    tick();
    chk("edge8_resp_valid", {31'd0, o_resp_valid}, 32'd1);
    wait_resp("edge8");

    // Backpressure with a held request, then back-to-back accept
    i_resp_ready = 1'b0;
    i_prdata     = 32'hCAFE_0001;
    push(32'hCAFE_0001, 1'b0, 1'b0);
    push(32'h0, 1'b0, 1'b0);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0040;
    i_req_write = 1'b0;
    tick();
    i_req_addr  = 32'h0000_0044;
    i_req_write = 1'b1;
    i_req_wdata = 32'h0000_00BB;
    i_req_wstrb = 4'h1;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
      chk("bp_psel", {31'd0, o_psel}, 32'd0);
      chk("bp_resp_valid", {31'd0, o_resp_valid}, 32'd1);
      chk("bp_rdata_stable", o_resp_rdata, sb[0].rdata);
      tick();
    end
    check_resp("bp_a");
    i_resp_ready = 1'b1;
    tick();
    chk("b2b_ready_after_hs", {31'd0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 1'b0;
    chk("b2b_accepted_psel", {31'd0, o_psel}, 32'd1);
    chk("b2b_paddr", o_paddr, 32'h0000_0044);
    chk("b2b_pwdata", o_pwdata, 32'h0000_00BB);
    wait_resp("bp_b");

    // Async reset during ACCESS
    i_pready = 1'b0;
    issue(32'h0000_0050, 1'b0, 32'h0, 4'h0);
    tick();
    chk("rst_mid_access", {31'd0, o_penable}, 32'd1);
    #2 i_pwrreset = 1'b1;
    #1;
    chk("rst_async_psel", {31'd0, o_psel}, 32'd0);
    chk("rst_async_penable", {31'd0, o_penable}, 32'd0);
    chk("rst_async_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_async_req_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_async_paddr", o_paddr, 32'd0);
    sb.delete();
    tick();
    #2 i_pwrreset = 1'b0;
    #1 chk("rst2_ready_low", {31'd0, o_req_ready}, 32'd0);
    tick();
    chk("rst2_ready_high", {31'd0, o_req_ready}, 32'd1);

    // Normal operation after reset
    i_pready = 1'b1;
    i_prdata = 32'h0000_0077;
    push(32'h0000_0077, 1'b0, 1'b0);
    issue(32'h0000_0060, 1'b0, 32'h0, 4'h0);
    wait_resp("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
